burst_capture_buf: RTL

//  Parametrised burst capture buffer: on a start pulse, writes up to DEPTH consecutive

---
 rtl/burst_capture_buf_if.sv | 34 +++
 rtl/burst_capture_buf.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/burst_capture_buf_if.sv
// Bundle of the capture buffer's control, sample, status and read-port signals.
// The master side drives the requests and samples; the slave side is the buffer.
interface burst_capture_buf_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             enable;
    logic             start;
    logic             abort;
    logic             clear;
    logic             mode;
    logic [AW:0]      burst_len;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic             busy;
    logic             done;
    logic             wrapped;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output enable, start, abort, clear, mode, burst_len, din, din_vld, rd_addr,
        input  busy, done, wrapped, wr_ptr, count, rd_data
    );

    modport slave (
        input  enable, start, abort, clear, mode, burst_len, din, din_vld, rd_addr,
        output busy, done, wrapped, wr_ptr, count, rd_data
    );
endinterface

// File: rtl/burst_capture_buf.sv
// Burst capture buffer: records up to DEPTH qualified samples after a start request,
// either as a single-shot burst of a latched length or as a continuous ring.
// Provides abort, whole-buffer clear outside capture, and a registered read port.
module burst_capture_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    burst_capture_buf_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    len_sel;
    logic             mode_q;
    logic             wrapped;
    logic [WIDTH-1:0] rd_data;
    logic             busy_c;
    logic             done_c;

    logic launch;
    logic wr_en;
    logic clr_en;
    logic last_wr;

    // A burst may only launch from IDLE; a same-cycle clear suppresses it.
    assign launch  = (state == IDLE) && bus.start && bus.enable && !bus.clear;
    // Abort drops any write presented in the same cycle.
    assign wr_en   = (state == CAPTURE) && bus.din_vld && bus.enable && !bus.abort;
    assign clr_en  = ((state == IDLE) || (state == DONE)) && bus.clear;
    assign last_wr = wr_en && !mode_q && ((count + 1'b1) == len_q);

    // Zero or oversize lengths fall back to a full-depth burst.
    always_comb begin
        len_sel = bus.burst_len;
        if ((bus.burst_len == '0) || (bus.burst_len > DEPTH_C)) begin
            len_sel = DEPTH_C;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; DONE lasts exactly one cycle and ignores start.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (last_wr) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: pointer, saturating count, sticky wrap flag, latched mode/length.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            mode_q  <= 1'b0;
            len_q   <= '0;
        end else if (launch) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            mode_q  <= bus.mode;
            len_q   <= len_sel;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            if (count != DEPTH_C) begin
                count <= count + 1'b1;
            end
            if (mode_q && (wr_ptr == LAST_C)) begin
                wrapped <= 1'b1;
            end
        end
    end

    // Sample storage; clear wipes every entry at once and never coincides with a write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Registered read; a same-cycle write is not forwarded, out-of-range reads give zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if ({1'b0, bus.rd_addr} < DEPTH_C) begin
            rd_data <= mem[bus.rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.wrapped = wrapped;
    assign bus.wr_ptr  = wr_ptr;
    assign bus.count   = count;
    assign bus.rd_data = rd_data;
endmodule
